// File: rtl/rf_rr_arbiter_if.sv
// Requester-side bundle for rf_rr_arbiter.
// One instance per requester; the arbiter takes the slave side.
interface rf_rr_arbiter_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int RF_WIDTH   = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [RF_WIDTH-1:0]   wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [RF_WIDTH-1:0]   rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/rf_rr_arbiter.sv
// Round-robin sharing of one single-port register file by two requesters.
// Registered command stage plus a two-deep read tag pipeline.
module rf_rr_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int RF_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  rf_rr_arbiter_if.slave        a,
  rf_rr_arbiter_if.slave        b,
  output logic                  rf_write_enable,
  output logic                  rf_read_enable,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [RF_WIDTH-1:0]   rf_write_data,
  input  logic [RF_WIDTH-1:0]   rf_read_data,
  output logic                  busy
);

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  logic                  ptr_q, ptr_d;
  logic                  gnt_a_q, gnt_a_d;
  logic                  gnt_b_q, gnt_b_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RF_WIDTH-1:0]   wdata_q, wdata_d;
  logic                  s1v_q, s1v_d;
  logic                  s1id_q, s1id_d;
  logic                  s2v_q, s2v_d;
  logic                  s2id_q, s2id_d;
  logic                  rva_q, rva_d;
  logic                  rvb_q, rvb_d;
  logic [RF_WIDTH-1:0]   rda_q, rda_d;
  logic [RF_WIDTH-1:0]   rdb_q, rdb_d;
  logic                  busy_q, busy_d;

  logic                  elig_a, elig_b;
  logic                  any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [RF_WIDTH-1:0]   sel_wdata;

  // Arbitration, command formation and read-tag advance.
  always_comb begin
    elig_a    = a.req & ~gnt_a_q;
    elig_b    = b.req & ~gnt_b_q;
    gnt_a_d   = elig_a & (~elig_b | (ptr_q == PTR_A));
    gnt_b_d   = elig_b & ~gnt_a_d;
    any_gnt   = gnt_a_d | gnt_b_d;
    sel_we    = gnt_b_d ? b.we    : a.we;
    sel_addr  = gnt_b_d ? b.addr  : a.addr;
    sel_wdata = gnt_b_d ? b.wdata : a.wdata;

    ptr_d = ptr_q;
    unique case (1'b1)
      gnt_a_d: ptr_d = PTR_B;
      gnt_b_d: ptr_d = PTR_A;
      default: ptr_d = ptr_q;
    endcase

    we_d    = any_gnt & sel_we;
    re_d    = any_gnt & ~sel_we;
    addr_d  = any_gnt ? sel_addr : addr_q;
    wdata_d = we_d ? sel_wdata : wdata_q;

    s1v_d  = re_d;
    s1id_d = re_d ? gnt_b_d : s1id_q;
    s2v_d  = s1v_q;
    s2id_d = s1id_q;

    rva_d = s2v_q & ~s2id_q;
    rvb_d = s2v_q & s2id_q;
    rda_d = rva_d ? rf_read_data : rda_q;
    rdb_d = rvb_d ? rf_read_data : rdb_q;

    busy_d = we_d | re_d | s1v_d | s2v_d;
  end

  // State update; reset drops any in-flight reads.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q   <= PTR_A;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      s1v_q   <= 1'b0;
      s1id_q  <= 1'b0;
      s2v_q   <= 1'b0;
      s2id_q  <= 1'b0;
      rva_q   <= 1'b0;
      rvb_q   <= 1'b0;
      rda_q   <= '0;
      rdb_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      s1v_q   <= s1v_d;
      s1id_q  <= s1id_d;
      s2v_q   <= s2v_d;
      s2id_q  <= s2id_d;
      rva_q   <= rva_d;
      rvb_q   <= rvb_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      busy_q  <= busy_d;
    end
  end

  assign a.gnt    = gnt_a_q;
  assign a.rvalid = rva_q;
  assign a.rdata  = rda_q;
  assign b.gnt    = gnt_b_q;
  assign b.rvalid = rvb_q;
  assign b.rdata  = rdb_q;

  assign rf_write_enable = we_q;
  assign rf_read_enable  = re_q;
  assign rf_address      = addr_q;
  assign rf_write_data   = wdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_rf_rr_arbiter.sv
// Directed vector bench for rf_rr_arbiter.
// Includes a behavioural 8x16 register file with registered read data.
module tb_rf_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        rf_we, rf_re, busy;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wd;
  logic [15:0] rf_rd;
  logic [15:0] mem [8];

  int checks = 0;
  int failures = 0;

  rf_rr_arbiter_if #(.ADDR_WIDTH(3), .RF_WIDTH(16)) ia ();
  rf_rr_arbiter_if #(.ADDR_WIDTH(3), .RF_WIDTH(16)) ib ();

  rf_rr_arbiter #(.ADDR_WIDTH(3), .RF_WIDTH(16)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .a               (ia.slave),
    .b               (ib.slave),
    .rf_write_enable (rf_we),
    .rf_read_enable  (rf_re),
    .rf_address      (rf_addr),
    .rf_write_data   (rf_wd),
    .rf_read_data    (rf_rd),
    .busy            (busy)
  );

  always #5 CLK = ~CLK;

  // Register file model sharing the arbiter reset.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      rf_rd <= '0;
    end else begin
      if (rf_we) mem[rf_addr] <= rf_wd;
      if (rf_re) rf_rd <= mem[rf_addr];
    end
  end

  typedef struct packed {
    logic        ra, wa;
    logic [2:0]  aa;
    logic [15:0] da;
    logic        rb, wb;
    logic [2:0]  ab;
    logic [15:0] db;
    logic        ga, gb, va, vb;
    logic [15:0] rda, rdb;
    logic        we, re, bsy;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ra, wa, input logic [2:0] aa,
                       input logic [15:0] da, input logic rb, wb,
                       input logic [2:0] ab, input logic [15:0] db);
    ia.req = ra; ia.we = wa; ia.addr = aa; ia.wdata = da;
    ib.req = rb; ib.we = wb; ib.addr = ab; ib.wdata = db;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".gnt_a"}, {15'd0, ia.gnt}, 16'd0);
    chk({nm, ".gnt_b"}, {15'd0, ib.gnt}, 16'd0);
    chk({nm, ".rvalid_a"}, {15'd0, ia.rvalid}, 16'd0);
    chk({nm, ".rvalid_b"}, {15'd0, ib.rvalid}, 16'd0);
    chk({nm, ".we"}, {15'd0, rf_we}, 16'd0);
    chk({nm, ".re"}, {15'd0, rf_re}, 16'd0);
    chk({nm, ".busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    // ra wa aa da  rb wb ab db | ga gb va vb rda rdb we re busy
    vt[0]  = '{1,1,3,16'hBEEF, 0,0,0,0, 1,0,0,0, 0,0, 1,0,1};
    vt[1]  = '{1,0,3,0,        0,0,0,0, 0,0,0,0, 0,0, 0,0,0};
    vt[2]  = '{1,0,3,0,        0,0,0,0, 1,0,0,0, 0,0, 0,1,1};
    vt[3]  = '{0,0,0,0,        0,0,0,0, 0,0,0,0, 0,0, 0,0,1};
    vt[4]  = '{0,0,0,0,        0,0,0,0, 0,0,1,0, 16'hBEEF,0, 0,0,0};
    vt[5]  = '{0,0,0,0,        0,0,0,0, 0,0,0,0, 16'hBEEF,0, 0,0,0};
    vt[6]  = '{0,0,0,0,        1,1,0,16'h0B0B, 0,1,0,0, 16'hBEEF,0, 1,0,1};
    vt[7]  = '{0,0,0,0,        0,0,0,0, 0,0,0,0, 16'hBEEF,0, 0,0,0};
    vt[8]  = '{1,1,1,16'h1111, 1,1,2,16'h2222, 1,0,0,0, 16'hBEEF,0, 1,0,1};
    vt[9]  = '{1,1,1,16'h1111, 1,1,2,16'h2222, 0,1,0,0, 16'hBEEF,0, 1,0,1};
    vt[10] = '{1,1,1,16'h1111, 1,1,2,16'h2222, 1,0,0,0, 16'hBEEF,0, 1,0,1};
    vt[11] = '{1,1,1,16'h1111, 1,1,2,16'h2222, 0,1,0,0, 16'hBEEF,0, 1,0,1};
    vt[12] = '{0,0,0,0,        0,0,0,0, 0,0,0,0, 16'hBEEF,0, 0,0,0};
    vt[13] = '{1,0,1,0,        1,0,2,0, 1,0,0,0, 16'hBEEF,0, 0,1,1};
    vt[14] = '{0,0,0,0,        1,0,2,0, 0,1,0,0, 16'hBEEF,0, 0,1,1};
    vt[15] = '{0,0,0,0,        0,0,0,0, 0,0,1,0, 16'h1111,0, 0,0,1};
    vt[16] = '{0,0,0,0,        0,0,0,0, 0,0,0,1, 16'h1111,16'h2222, 0,0,0};
    vt[17] = '{1,1,5,16'h00A5, 1,0,5,0, 1,0,0,0, 16'h1111,16'h2222, 1,0,1};
    vt[18] = '{0,0,0,0,        1,0,5,0, 0,1,0,0, 16'h1111,16'h2222, 0,1,1};
    vt[19] = '{0,0,0,0,        0,0,0,0, 0,0,0,0, 16'h1111,16'h2222, 0,0,1};
    vt[20] = '{0,0,0,0,        0,0,0,0, 0,0,0,1, 16'h1111,16'h00A5, 0,0,0};
    vt[21] = '{0,0,0,0,        0,0,0,0, 0,0,0,0, 16'h1111,16'h00A5, 0,0,0};

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_idle("rst");
    chk("rst.rdata_a", ia.rdata, 16'h0);
    chk("rst.rdata_b", ib.rdata, 16'h0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].ra, vt[i].wa, vt[i].aa, vt[i].da,
            vt[i].rb, vt[i].wb, vt[i].ab, vt[i].db);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d.gnt_a", i), {15'd0, ia.gnt}, {15'd0, vt[i].ga});
      chk($sformatf("v%0d.gnt_b", i), {15'd0, ib.gnt}, {15'd0, vt[i].gb});
      chk($sformatf("v%0d.rvalid_a", i), {15'd0, ia.rvalid},
          {15'd0, vt[i].va});
      chk($sformatf("v%0d.rvalid_b", i), {15'd0, ib.rvalid},
          {15'd0, vt[i].vb});
      chk($sformatf("v%0d.rdata_a", i), ia.rdata, vt[i].rda);
      chk($sformatf("v%0d.rdata_b", i), ib.rdata, vt[i].rdb);
      chk($sformatf("v%0d.we", i), {15'd0, rf_we}, {15'd0, vt[i].we});
      chk($sformatf("v%0d.re", i), {15'd0, rf_re}, {15'd0, vt[i].re});
      chk($sformatf("v%0d.busy", i), {15'd0, busy}, {15'd0, vt[i].bsy});
      chk($sformatf("v%0d.excl", i), {15'd0, (ia.gnt & ib.gnt) |
          (rf_we & rf_re)}, 16'd0);
    end

    // Reset one cycle after a read grant drops the pending read.
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    chk("mid.gnt_a", {15'd0, ia.gnt}, 16'd1);
    chk("mid.re", {15'd0, rf_re}, 16'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst.rdata_a", ia.rdata, 16'h0);
    chk("mid_rst.rdata_b", ib.rdata, 16'h0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      chk_idle($sformatf("post%0d", i));
    end
    drive(1, 0, 3, 0, 1, 0, 2, 0);
    @(posedge CLK);
    #1;
    chk("post.gnt_a", {15'd0, ia.gnt}, 16'd1);
    chk("post.gnt_b", {15'd0, ib.gnt}, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
